// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined memory port between the icache and
// dcache miss handlers, one block fill or single-word store at a time.
module mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BLK_WORDS = 8,
  localparam int IDX_W    = $clog2(BLK_WORDS),
  localparam int OFF_W    = $clog2(2 * BLK_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_data_vld,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_data_vld,
  output logic              d_done,
  output logic [IDX_W-1:0]  word_idx,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_data_valid,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    I_FILL,
    D_FILL,
    D_WRITE
  } state_t;

  localparam logic [IDX_W:0] CNT_END  = (IDX_W + 1)'(BLK_WORDS);
  localparam logic [IDX_W:0] CNT_LAST = (IDX_W + 1)'(BLK_WORDS - 1);

  state_t            state;
  state_t            nxtState;
  logic              lastGrantD;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] wdat;
  logic [IDX_W:0]    issCnt;
  logic [IDX_W:0]    retCnt;

  logic isFill;
  logic issuing;
  logic accept;
  logic lastRet;
  logic iWin;
  logic dWin;

  assign isFill  = (state == I_FILL) || (state == D_FILL);
  assign issuing = isFill && (issCnt < CNT_END);
  assign accept  = isFill && mem_data_valid;
  assign lastRet = accept && (retCnt == CNT_LAST);
  // ties go to the side that was not granted last
  assign iWin    = i_req && (!d_req || lastGrantD);
  assign dWin    = d_req && !iWin;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxtState;
    end
  end

  always_comb begin
    nxtState = state;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          iWin:    nxtState = I_FILL;
          dWin:    nxtState = d_wr ? D_WRITE : D_FILL;
          default: nxtState = IDLE;
        endcase
      end
      I_FILL, D_FILL: begin
        if (lastRet) nxtState = IDLE;
      end
      D_WRITE: nxtState = IDLE;
      default: nxtState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lastGrantD <= 1'b0;
      base       <= '0;
      wdat       <= '0;
      issCnt     <= '0;
      retCnt     <= '0;
    end else if (state == IDLE) begin
      issCnt <= '0;
      retCnt <= '0;
      if (nxtState != IDLE) begin
        lastGrantD <= (nxtState != I_FILL);
        base       <= (nxtState == I_FILL) ? i_addr : d_addr;
        wdat       <= d_wdata;
      end
    end else begin
      if (issuing) issCnt <= issCnt + 1'b1;
      if (accept)  retCnt <= retCnt + 1'b1;
    end
  end

  always_comb begin
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    i_data_vld = 1'b0;
    d_data_vld = 1'b0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    word_idx   = '0;
    rdata      = '0;
    unique case (state)
      I_FILL, D_FILL: begin
        mem_en   = issuing;
        word_idx = retCnt[IDX_W-1:0];
        if (issuing) begin
          mem_addr = {base[ADDR_W-1:OFF_W], issCnt[IDX_W-1:0], 1'b0};
        end
        if (accept) begin
          rdata      = mem_data_in;
          i_data_vld = (state == I_FILL);
          d_data_vld = (state == D_FILL);
        end
        i_done = lastRet && (state == I_FILL);
        d_done = lastRet && (state == D_FILL);
      end
      D_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = base;
        mem_wdata = wdat;
        d_done    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios against a 4-cycle memory model,
// with memory commands and returned words checked from queues.
module tb_mem_arbiter;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic        side;
    logic [2:0]  idx;
    logic [15:0] data;
  } ret_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_data_vld;
  logic        i_done;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_data_vld;
  logic        d_done;
  logic [2:0]  word_idx;
  logic [15:0] rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_data_in;
  logic        mem_data_valid;
  logic        busy;
  logic        stray;

  logic [3:0]  pV = '0;
  logic [15:0] pA [4];

  cmd_t cmdQ [$];
  ret_t retQ [$];
  int   checks   = 0;
  int   fails    = 0;
  int   iDoneCnt = 0;
  int   dDoneCnt = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .i_req         (i_req),
    .i_addr        (i_addr),
    .i_data_vld    (i_data_vld),
    .i_done        (i_done),
    .d_req         (d_req),
    .d_wr          (d_wr),
    .d_addr        (d_addr),
    .d_wdata       (d_wdata),
    .d_data_vld    (d_data_vld),
    .d_done        (d_done),
    .word_idx      (word_idx),
    .rdata         (rdata),
    .mem_en        (mem_en),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_data_in   (mem_data_in),
    .mem_data_valid(mem_data_valid),
    .busy          (busy)
  );

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  // four-cycle read latency memory
  always @(posedge clk) begin
    pV    <= {pV[2:0], (mem_en === 1'b1) && (mem_wr === 1'b0)};
    pA[0] <= mem_addr;
    pA[1] <= pA[0];
    pA[2] <= pA[1];
    pA[3] <= pA[2];
  end

  assign mem_data_valid = pV[3] | stray;
  assign mem_data_in    = pV[3] ? memWord(pA[3])
                        : (stray ? 16'hDEAD : 16'h0000);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t mkCmd(input logic wr, input logic [15:0] a,
                                 input logic [15:0] w);
    cmd_t c;
    c.wr    = wr;
    c.addr  = a;
    c.wdata = w;
    return c;
  endfunction

  function automatic ret_t mkRet(input logic s, input logic [2:0] i,
                                 input logic [15:0] d);
    ret_t r;
    r.side = s;
    r.idx  = i;
    r.data = d;
    return r;
  endfunction

  task automatic pushFill(input logic side, input logic [15:0] base);
    logic [15:0] a;
    for (int k = 0; k < 8; k++) begin
      a = {base[15:4], 3'(k), 1'b0};
      cmdQ.push_back(mkCmd(1'b0, a, 16'h0000));
      retQ.push_back(mkRet(side, 3'(k), memWord(a)));
    end
  endtask

  task automatic mon();
    cmd_t c;
    ret_t r;
    if (mem_en === 1'b1) begin
      if (cmdQ.size() == 0) begin
        chk("cmd_extra", 32'(mem_en), 32'd0);
      end else begin
        c = cmdQ.pop_front();
        chk("mem_wr", 32'(mem_wr), 32'(c.wr));
        chk("mem_addr", 32'(mem_addr), 32'(c.addr));
        if (c.wr) chk("mem_wdata", 32'(mem_wdata), 32'(c.wdata));
      end
    end
    if (i_data_vld === 1'b1 || d_data_vld === 1'b1) begin
      if (retQ.size() == 0) begin
        chk("vld_extra", 32'({i_data_vld, d_data_vld}), 32'd0);
      end else begin
        r = retQ.pop_front();
        chk("d_data_vld", 32'(d_data_vld), 32'(r.side));
        chk("i_data_vld", 32'(i_data_vld), 32'(!r.side));
        chk("word_idx", 32'(word_idx), 32'(r.idx));
        chk("rdata", 32'(rdata), 32'(r.data));
      end
    end
    if (i_done === 1'b1) iDoneCnt++;
    if (d_done === 1'b1) dDoneCnt++;
  endtask

  task automatic nxt();
    @(negedge clk);
    mon();
  endtask

  task automatic waitDone(input logic side, output int n);
    n = 0;
    do begin
      nxt();
      n++;
    end while (((side ? d_done : i_done) !== 1'b1) && n < 64);
  endtask

  initial begin
    int n;
    int dd;
    int id;
    logic found;
    rst = 1'b1;
    i_req = 1'b0;
    i_addr = '0;
    d_req = 1'b0;
    d_wr = 1'b0;
    d_addr = '0;
    d_wdata = '0;
    stray = 1'b0;
    repeat (3) nxt();
    rst = 1'b0;
    nxt();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_en", 32'({mem_en, mem_wr}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_rdata", 32'({rdata, word_idx}), 32'd0);
    chk("rst_flags", 32'({i_data_vld, d_data_vld, i_done, d_done}), 32'd0);

    // icache fill alone, checking cycle positions
    pushFill(1'b0, 16'h1234);
    i_req = 1'b1;
    i_addr = 16'h1234;
    for (int c = 1; c <= 13; c++) begin
      nxt();
      if (c == 1) chk("t1_first_en", 32'(mem_en), 32'd1);
      if (c == 4) chk("t1_no_early", 32'(i_data_vld), 32'd0);
      if (c == 5) chk("t1_w0", 32'({i_data_vld, word_idx}), 32'h8);
      if (c == 12) begin
        chk("t1_done", 32'(i_done), 32'd1);
        i_req = 1'b0;
      end
      if (c == 13) chk("t1_idle", 32'(busy), 32'd0);
    end
    chk("t1_queues", 32'(cmdQ.size() + retQ.size()), 32'd0);

    // write-through store
    cmdQ.push_back(mkCmd(1'b1, 16'h00A6, 16'hBEEF));
    dd = dDoneCnt;
    d_req = 1'b1;
    d_wr = 1'b1;
    d_addr = 16'h00A6;
    d_wdata = 16'hBEEF;
    waitDone(1'b1, n);
    chk("t2_lat", 32'(n), 32'd1);
    d_req = 1'b0;
    d_wr = 1'b0;
    nxt();
    chk("t2_idle", 32'(busy), 32'd0);
    chk("t2_done_once", 32'(dDoneCnt - dd), 32'd1);

    // ties right after reset: D first, then alternate
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    pushFill(1'b1, 16'h4000);
    pushFill(1'b0, 16'h2000);
    pushFill(1'b1, 16'h4000);
    pushFill(1'b0, 16'h2000);
    d_req = 1'b1;
    d_wr = 1'b0;
    d_addr = 16'h4000;
    i_req = 1'b1;
    i_addr = 16'h2000;
    waitDone(1'b1, n);
    chk("t3_d_first", 32'(n), 32'd12);
    waitDone(1'b0, n);
    chk("t3_i_second", 32'(n), 32'd13);
    waitDone(1'b1, n);
    chk("t3_d_third", 32'(n), 32'd13);
    d_req = 1'b0;
    waitDone(1'b0, n);
    chk("t3_i_fourth", 32'(n), 32'd13);
    i_req = 1'b0;
    nxt();
    chk("t3_queues", 32'(cmdQ.size() + retQ.size()), 32'd0);
    chk("t3_idle", 32'(busy), 32'd0);

    // dcache held high with icache pending: icache served next
    cmdQ.push_back(mkCmd(1'b1, 16'h0010, 16'h1111));
    pushFill(1'b0, 16'h2A00);
    cmdQ.push_back(mkCmd(1'b1, 16'h0010, 16'h1111));
    dd = dDoneCnt;
    d_req = 1'b1;
    d_wr = 1'b1;
    d_addr = 16'h0010;
    d_wdata = 16'h1111;
    nxt();
    chk("t4_store1", 32'(d_done), 32'd1);
    i_req = 1'b1;
    i_addr = 16'h2A00;
    waitDone(1'b0, n);
    chk("t4_i_next", 32'(n), 32'd13);
    chk("t4_one_d", 32'(dDoneCnt - dd), 32'd1);
    i_req = 1'b0;
    waitDone(1'b1, n);
    chk("t4_store2", 32'(n), 32'd2);
    d_req = 1'b0;
    d_wr = 1'b0;
    nxt();
    chk("t4_d_count", 32'(dDoneCnt - dd), 32'd2);

    // reset during an icache fill
    pushFill(1'b0, 16'h3000);
    i_req = 1'b1;
    i_addr = 16'h3000;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      nxt();
      if (i_data_vld === 1'b1 && word_idx == 3'd3) found = 1'b1;
    end
    chk("t5_word3", 32'(found), 32'd1);
    id = iDoneCnt;
    rst = 1'b1;
    i_req = 1'b0;
    nxt();
    rst = 1'b0;
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_all_issued", 32'(cmdQ.size()), 32'd0);
    chk("t5_late", 32'(retQ.size()), 32'd4);
    retQ.delete();
    for (int c = 0; c < 6; c++) begin
      nxt();
      chk("t5_quiet", 32'({i_data_vld, d_data_vld, rdata}), 32'd0);
    end
    chk("t5_no_done", 32'(iDoneCnt - id), 32'd0);
    pushFill(1'b1, 16'h5000);
    d_req = 1'b1;
    d_wr = 1'b0;
    d_addr = 16'h5000;
    waitDone(1'b1, n);
    chk("t5_dfill", 32'(n), 32'd12);
    d_req = 1'b0;
    nxt();
    chk("t5_queues", 32'(cmdQ.size() + retQ.size()), 32'd0);

    // store with a stray memory valid
    cmdQ.push_back(mkCmd(1'b1, 16'h0044, 16'h7777));
    dd = dDoneCnt;
    d_req = 1'b1;
    d_wr = 1'b1;
    d_addr = 16'h0044;
    d_wdata = 16'h7777;
    stray = 1'b1;
    nxt();
    chk("t6_done", 32'(d_done), 32'd1);
    chk("t6_vld", 32'({i_data_vld, d_data_vld}), 32'd0);
    chk("t6_rdata", 32'(rdata), 32'd0);
    stray = 1'b0;
    d_req = 1'b0;
    d_wr = 1'b0;
    nxt();
    chk("t6_done_low", 32'(d_done), 32'd0);
    chk("t6_idle", 32'(busy), 32'd0);
    chk("t6_count", 32'(dDoneCnt - dd), 32'd1);
    chk("t6_queues", 32'(cmdQ.size() + retQ.size()), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
